// File: rtl/unified_memory_mon_if.sv
// Bundles the data, instruction and monitor-stream signals of unified_memory_mon.
// master drives addresses, write data and sink ready; slave returns read data and characters.
interface unified_memory_mon_if #(
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32,
   parameter int MON_IDX_W = 4
);
   logic [ADDR_W-1:0]    d_addr;
   logic [DATA_W-1:0]    d_wdata;
   logic                 d_we;
   logic                 d_re;
   logic [DATA_W-1:0]    d_rdata;
   logic                 d_rvalid;
   logic                 d_err;
   logic [ADDR_W-1:0]    i_addr;
   logic [DATA_W-1:0]    i_rdata;
   logic                 mon_refresh;
   logic                 mon_valid;
   logic                 mon_ready;
   logic [MON_IDX_W-1:0] mon_index;
   logic [7:0]           mon_char;

   modport master (
      output d_addr, d_wdata, d_we, d_re, i_addr, mon_refresh, mon_ready,
      input  d_rdata, d_rvalid, d_err, i_rdata, mon_valid, mon_index, mon_char
   );

   modport slave (
      input  d_addr, d_wdata, d_we, d_re, i_addr, mon_refresh, mon_ready,
      output d_rdata, d_rvalid, d_err, i_rdata, mon_valid, mon_index, mon_char
   );
endinterface

// File: rtl/unified_memory_mon.sv
// Word-addressed unified I/D memory: registered data and instruction reads (read-first),
// out-of-range flagging, and a round-robin scanner streaming changed monitor-window characters.
module unified_memory_mon #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 512,
   parameter int ADDR_W   = 32,
   parameter int MON_BASE = 495,
   parameter int MON_LEN  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   unified_memory_mon_if.slave   bus
);
   localparam int IDX_W  = $clog2(DEPTH);
   localparam int MIDX_W = $clog2(MON_LEN);
   localparam logic [ADDR_W-1:0] DEPTH_A = ADDR_W'(DEPTH);
   localparam logic [ADDR_W-1:0] MON_LO  = ADDR_W'(MON_BASE);
   localparam logic [ADDR_W-1:0] MON_HI  = ADDR_W'(MON_BASE + MON_LEN);
   localparam logic [MIDX_W-1:0] PTR_MAX = MIDX_W'(MON_LEN - 1);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] SCAN = 2'd1;
   localparam logic [1:0] EMIT = 2'd2;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              d_ok, i_ok, wr_en, rd_en, win_hit;
   logic [IDX_W-1:0]  d_idx, i_idx, mon_addr;
   logic [MIDX_W-1:0] win_off, ptr, ptr_next;
   logic [MON_LEN-1:0] dirty, dirty_set, dirty_clr;
   logic [1:0]        state;

   logic [DATA_W-1:0] d_rdata_q, i_rdata_q;
   logic              d_rvalid_q, d_err_q, mon_valid_q;
   logic [MIDX_W-1:0] mon_index_q;
   logic [7:0]        mon_char_q;

   assign d_ok     = bus.d_addr < DEPTH_A;
   assign i_ok     = bus.i_addr < DEPTH_A;
   assign d_idx    = bus.d_addr[IDX_W-1:0];
   assign i_idx    = bus.i_addr[IDX_W-1:0];
   assign wr_en    = bus.d_we && d_ok;
   assign rd_en    = bus.d_re && !bus.d_we;
   assign win_hit  = wr_en && (bus.d_addr >= MON_LO) && (bus.d_addr < MON_HI);
   assign win_off  = MIDX_W'(bus.d_addr - MON_LO);
   assign mon_addr = IDX_W'(MON_BASE) + IDX_W'(ptr);
   assign ptr_next = (ptr == PTR_MAX) ? '0 : ptr + 1'b1;

   always_ff @(posedge clk) begin
      if (wr_en) mem[d_idx] <= bus.d_wdata;
   end

   // Out-of-range reads still complete (rvalid=1) but return zero.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         d_rdata_q  <= '0;
         d_rvalid_q <= 1'b0;
         d_err_q    <= 1'b0;
         i_rdata_q  <= '0;
      end else begin
         d_rvalid_q <= rd_en;
         d_err_q    <= (bus.d_we || bus.d_re) && !d_ok;
         if (rd_en) d_rdata_q <= d_ok ? mem[d_idx] : '0;
         i_rdata_q  <= i_ok ? mem[i_idx] : '0;
      end
   end

   // A same-cycle write to the word being captured re-sets its bit, so set beats clear.
   always_comb begin
      dirty_set = '0;
      dirty_clr = '0;
      if (bus.mon_refresh) dirty_set = '1;
      else if (win_hit)    dirty_set[win_off] = 1'b1;
      if (state == SCAN && dirty[ptr]) dirty_clr[ptr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         ptr         <= '0;
         dirty       <= '0;
         mon_valid_q <= 1'b0;
         mon_index_q <= '0;
         mon_char_q  <= '0;
      end else begin
         dirty <= (dirty & ~dirty_clr) | dirty_set;
         case (state)
            IDLE: if (|dirty) state <= SCAN;
            SCAN: begin
               if (dirty[ptr]) begin
                  mon_char_q  <= mem[mon_addr][7:0];
                  mon_index_q <= ptr;
                  mon_valid_q <= 1'b1;
                  state       <= EMIT;
               end else if (~|dirty) begin
                  state <= IDLE;
               end else begin
                  ptr <= ptr_next;
               end
            end
            EMIT: if (bus.mon_ready) begin
               mon_valid_q <= 1'b0;
               ptr         <= ptr_next;
               state       <= SCAN;
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.d_rdata   = d_rdata_q;
   assign bus.d_rvalid  = d_rvalid_q;
   assign bus.d_err     = d_err_q;
   assign bus.i_rdata   = i_rdata_q;
   assign bus.mon_valid = mon_valid_q;
   assign bus.mon_index = mon_index_q;
   assign bus.mon_char  = mon_char_q;
endmodule

// File: tb/tb_unified_memory_mon.sv
// Bench for unified_memory_mon: directed monitor-stream scenarios plus randomized data/instruction
// traffic checked against an array-based memory model.
module tb_unified_memory_mon;
   localparam int DATA_W   = 32;
   localparam int DEPTH    = 512;
   localparam int ADDR_W   = 32;
   localparam int MON_BASE = 495;
   localparam int MON_LEN  = 16;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   unified_memory_mon_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MON_IDX_W(4)) bus ();

   unified_memory_mon #(
      .DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
      .MON_BASE(MON_BASE), .MON_LEN(MON_LEN)
   ) dut (
      .clk(clk),
      .rst_n(rst_n),
      .bus(bus)
   );

   int checks = 0;
   int failures = 0;

   logic [31:0] ref_mem [DEPTH];
   logic [31:0] exp_rdata = '0;
   logic [11:0] emits [$];

   // Handshakes are recorded half a cycle before the edge that completes them.
   always @(negedge clk)
      if (rst_n && bus.mon_valid && bus.mon_ready)
         emits.push_back({bus.mon_index, bus.mon_char});

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic we, input logic re, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] iaddr);
      logic ok, iok, exp_v, exp_e;
      logic [31:0] exp_i;
      bus.d_we = we; bus.d_re = re; bus.d_addr = addr; bus.d_wdata = wdata; bus.i_addr = iaddr;
      ok    = addr < DEPTH;
      iok   = iaddr < DEPTH;
      exp_v = re && !we;
      exp_e = (we || re) && !ok;
      if (exp_v) exp_rdata = ok ? ref_mem[addr[8:0]] : 32'h0;
      exp_i = iok ? ref_mem[iaddr[8:0]] : 32'h0;
      if (we && ok) ref_mem[addr[8:0]] = wdata;
      step();
      bus.d_we = 1'b0; bus.d_re = 1'b0;
      chk("d_rvalid", 32'(bus.d_rvalid), 32'(exp_v));
      chk("d_rdata", bus.d_rdata, exp_rdata);
      chk("d_err", 32'(bus.d_err), 32'(exp_e));
      chk("i_rdata", bus.i_rdata, exp_i);
   endtask

   task automatic raw_write(input int a);
      logic [31:0] v;
      v = $urandom;
      bus.d_we = 1'b1; bus.d_addr = 32'(a); bus.d_wdata = v;
      ref_mem[a] = v;
      step();
      bus.d_we = 1'b0;
   endtask

   task automatic wait_valid(input string tag);
      int n = 0;
      while (!bus.mon_valid && n < 20) begin step(); n++; end
      chk(tag, 32'(bus.mon_valid), 32'd1);
   endtask

   task automatic wait_emits(input string tag, input int cnt);
      int n = 0;
      while (emits.size() < cnt && n < 200) begin step(); n++; end
      chk(tag, 32'(emits.size()), 32'(cnt));
   endtask

   function automatic logic [31:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r < 8)  return 32'($urandom_range(0, 31));
      if (r == 8) return 32'd88;
      return ($urandom_range(0, 1) == 1) ? 32'hFFFF_FFFF : 32'($urandom_range(512, 2000));
   endfunction

   initial begin
      bus.d_addr = '0; bus.d_wdata = '0; bus.d_we = 1'b0; bus.d_re = 1'b0;
      bus.i_addr = '0; bus.mon_refresh = 1'b0; bus.mon_ready = 1'b1;

      step(); step();
      chk("rst_d_rdata", bus.d_rdata, 32'h0);
      chk("rst_d_rvalid", 32'(bus.d_rvalid), 32'h0);
      chk("rst_d_err", 32'(bus.d_err), 32'h0);
      chk("rst_i_rdata", bus.i_rdata, 32'h0);
      chk("rst_mon_valid", 32'(bus.mon_valid), 32'h0);
      chk("rst_mon_index", 32'(bus.mon_index), 32'h0);
      chk("rst_mon_char", 32'(bus.mon_char), 32'h0);

      // Give every address the bench will read a known value, then clear the scanner.
      rst_n = 1'b1;
      for (int a = 0; a < 32; a++) raw_write(a);
      raw_write(88);
      for (int a = MON_BASE; a < MON_BASE + MON_LEN; a++) raw_write(a);
      repeat (60) step();
      rst_n = 1'b0; step(); rst_n = 1'b1;
      exp_rdata = '0;
      emits.delete();

      drive(1, 0, 3, 32'h8, 0);
      drive(0, 1, 3, 32'h0, 3);
      chk("t1_rdata", bus.d_rdata, 32'h8);
      chk("t1_rvalid", 32'(bus.d_rvalid), 32'h1);
      drive(0, 0, 0, 32'h0, 3);
      chk("t1_rvalid_once", 32'(bus.d_rvalid), 32'h0);
      chk("t1_i_rdata", bus.i_rdata, 32'h8);

      drive(1, 0, 7, 32'h11, 0);
      drive(1, 0, 7, 32'h55, 7);
      chk("t2_read_first", bus.i_rdata, 32'h11);
      drive(0, 1, 7, 32'h0, 7);
      chk("t2_new_data", bus.d_rdata, 32'h55);

      drive(1, 0, 600, 32'hDEAD_BEEF, 0);
      chk("t3_err_wr", 32'(bus.d_err), 32'h1);
      drive(0, 1, 600, 32'h0, 0);
      chk("t3_rdata_zero", bus.d_rdata, 32'h0);
      chk("t3_err_rd", 32'(bus.d_err), 32'h1);
      drive(0, 0, 0, 32'h0, 0);
      chk("t3_err_pulse", 32'(bus.d_err), 32'h0);
      drive(0, 1, 88, 32'h0, 88);
      drive(1, 1, 5, 32'h1234_5678, 5);
      drive(0, 1, 5, 32'h0, 0);

      for (int k = 0; k < 300; k++)
         drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), pick_addr(), $urandom, pick_addr());
      chk("rand_no_emits", 32'(emits.size()), 32'h0);

      bus.mon_ready = 1'b0;
      drive(1, 0, 495, 32'h77, 0);
      drive(1, 0, 496, 32'h65, 0);
      wait_valid("t4_valid");
      for (int k = 0; k < 5; k++) begin
         chk("t4_hold_valid", 32'(bus.mon_valid), 32'h1);
         chk("t4_hold_index", 32'(bus.mon_index), 32'h0);
         chk("t4_hold_char", 32'(bus.mon_char), 32'h77);
         step();
      end
      emits.delete();
      bus.mon_ready = 1'b1;
      wait_emits("t4_count", 2);
      if (emits.size() >= 2) begin
         chk("t4_emit0", 32'(emits[0]), 32'h077);
         chk("t4_emit1", 32'(emits[1]), 32'h165);
      end
      repeat (20) step();
      chk("t4_final_count", 32'(emits.size()), 32'h2);
      chk("t4_idle", 32'(bus.mon_valid), 32'h0);

      bus.mon_ready = 1'b0;
      emits.delete();
      drive(1, 0, 497, 32'h41, 0);
      wait_valid("t5_valid");
      chk("t5_index", 32'(bus.mon_index), 32'h2);
      chk("t5_char", 32'(bus.mon_char), 32'h41);
      drive(1, 0, 497, 32'h6c, 0);
      chk("t5_stable_char", 32'(bus.mon_char), 32'h41);
      bus.mon_ready = 1'b1;
      wait_emits("t5_count", 2);
      if (emits.size() >= 2) begin
         chk("t5_emit0", 32'(emits[0]), 32'h241);
         chk("t5_emit1", 32'(emits[1]), 32'h26c);
      end

      rst_n = 1'b0; step(); rst_n = 1'b1;
      emits.delete();
      bus.mon_refresh = 1'b1; step(); bus.mon_refresh = 1'b0;
      wait_emits("t6_count", 16);
      for (int i = 0; i < MON_LEN && i < emits.size(); i++)
         chk("t6_emit", 32'(emits[i]), 32'({4'(i), ref_mem[MON_BASE + i][7:0]}));
      repeat (20) step();
      chk("t6_final_count", 32'(emits.size()), 32'd16);

      emits.delete();
      bus.mon_refresh = 1'b1; step(); bus.mon_refresh = 1'b0;
      wait_emits("t6b_count", 5);
      step();
      chk("t6b_valid_before_rst", 32'(bus.mon_valid), 32'h1);
      rst_n = 1'b0;
      #1;
      chk("t6b_valid_dropped", 32'(bus.mon_valid), 32'h0);
      step(); step();
      rst_n = 1'b1;
      repeat (40) step();
      chk("t6b_no_more_emits", 32'(emits.size()), 32'd5);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/unified_memory_mon.md
Name: unified_memory_mon

Overview:
- Parametrised, word-addressed unified instruction/data memory for the single-cycle MIPS core.
- Adds a second, read-only instruction port and registered data reads.
- Out-of-range accesses are detected and flagged.
- A hardware monitor scanner tracks writes into the monitor window and streams each changed character over a valid/ready interface to the display/log sink.

Parameters:
DATA_W, 32, data word width in bits
DEPTH, 512, number of words
ADDR_W, 32, address port width (word address, not byte address)
MON_BASE, 495, first word of the monitor window
MON_LEN, 16, number of monitor words (MON_BASE+MON_LEN <= DEPTH)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
d_addr  in  ADDR_W  data-port word address
d_wdata  in  DATA_W  write data
d_we  in  1  write enable
d_re  in  1  read enable
d_rdata  out  DATA_W  registered read data
d_rvalid  out  1  d_rdata valid this cycle
d_err  out  1  one-cycle pulse: access with d_addr >= DEPTH
i_addr  in  ADDR_W  instruction-port word address
i_rdata  out  DATA_W  registered instruction word
mon_refresh  in  1  pulse: mark all monitor words dirty
mon_valid  out  1  monitor character offered
mon_ready  in  1  sink accepts character
mon_index  out  $clog2(MON_LEN)  offset of the character within the window
mon_char  out  8  low 8 bits of the monitor word

Behaviour:
- Reset (async, rst_n=0) clears the following outputs/registers to 0:
  - d_rdata, d_rvalid, d_err, i_rdata
  - mon_valid, mon_index, mon_char
  - dirty vector, scan pointer
  - FSM returns to IDLE
- Memory array contents are not reset.
- Reset asserted mid-emission drops mon_valid immediately.

Data port:
- Write: d_we=1 and d_addr<DEPTH -> word written at the clk edge.
- d_we has priority over d_re; when both are 1, the access is a write only and d_rvalid=0.
- Read: d_re=1 (d_we=0) -> d_rdata = mem[d_addr] on the next cycle, with d_rvalid=1 for exactly that cycle.
- When d_rvalid=0, d_rdata holds its last value.
- Out-of-range (d_addr>=DEPTH with d_we or d_re):
  - write is dropped;
  - read returns 0 with d_rvalid=1;
  - d_err=1 the next cycle.

Instruction port:
- Read every cycle; i_rdata = mem[i_addr] one cycle later.
- Out-of-range returns 0 (no error flag).
- Read-during-write at the same address, on either port: returns the old data (read-first).

Monitor tracking:
- An in-range write with MON_BASE <= d_addr < MON_BASE+MON_LEN sets dirty[d_addr-MON_BASE].
- mon_refresh sets all dirty bits.
- Set always wins over a same-cycle clear.

Scanner FSM:
- IDLE:
  - if any dirty bit is set -> SCAN;
  - otherwise stay.
- SCAN (one pointer step per cycle):
  - if dirty[ptr]=1: capture mon_char = mem[MON_BASE+ptr][7:0] and mon_index = ptr, clear dirty[ptr], go to EMIT;
  - else ptr = ptr+1 (wraps MON_LEN-1 -> 0);
  - if no dirty bits remain -> IDLE.
- EMIT:
  - mon_valid=1; mon_index and mon_char are held stable until mon_ready=1.
  - On mon_valid & mon_ready: ptr wraps/increments, mon_valid=0 the next cycle, return to SCAN.
- A write to the word currently being captured or emitted re-sets its dirty bit; the new value is emitted on a later pass, never lost.
- Ordering is round-robin from the pointer; each dirty word is emitted at most once per pass.

Test Plan:
- Reset, write mem[3]=0x8 on cycle 1, then read addr 3 -> d_rdata=0x00000008 with d_rvalid=1 exactly one cycle after the read; i_addr=3 gives the same value.
- Same-edge write 0x55 and i_addr read of addr 7 (old value 0x11) -> i_rdata=0x11; the following read gives 0x55.
- Write to addr 600, then read addr 600 -> no memory change, d_rdata=0, d_err pulses exactly once per access.
- Write 0x77 to 495 and 0x65 to 496 with mon_ready held low for 5 cycles -> mon_valid stays 1 with index 0, char 0x77 stable; after ready rises: index 0 then index 1/0x65, then IDLE.
- While index 2 is being emitted, rewrite addr 497 with 0x6c -> index 2 is emitted twice, the second time with 0x6c.
- Assert mon_refresh, hold mon_ready=1 -> exactly 16 emissions, indices 0..15 in order; rst_n low mid-stream -> mon_valid=0 immediately and no further emissions.
